// File: rtl/adder_share_arbiter.sv
// One adder shared by NUM_REQ round-robin requesters; one registered result slot.
// 1-cycle latency; out_valid & !out_ready stalls the slot and withholds every req_ready.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

module adder_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 6,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic                     out_cout,
  output logic [ID_W-1:0]          out_id,
  output logic [TAG_W-1:0]         out_tag,
  output logic [31:0]              op_count
);

  logic [ID_W-1:0]  rr_ptr;
  logic             can_accept;
  logic             grant_vld;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  scan_idx;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [TAG_W-1:0] win_tag;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  assign can_accept = !out_valid || out_ready;

  // Scan from rr_ptr; NUM_REQ is a power of two so the index wraps naturally.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = rr_ptr + ID_W'(k);
      if (!grant_vld && req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
    if (!can_accept || rst) begin
      grant_vld = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Only the winner's slice reaches the adder, so junk on other lanes cannot leak out.
  always_comb begin
    win_a   = '0;
    win_b   = '0;
    win_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vld && grant_idx == ID_W'(i)) begin
        win_a   = req_a[i*WIDTH +: WIDTH];
        win_b   = req_b[i*WIDTH +: WIDTH];
        win_tag = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  adder #(.WIDTH(WIDTH)) u_adder (
    .a    (win_a),
    .b    (win_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_id    <= '0;
      out_tag   <= '0;
      op_count  <= '0;
      rr_ptr    <= '0;
    end else begin
      if (out_valid && out_ready) begin
        op_count <= op_count + 32'd1;
      end
      if (grant_vld) begin
        out_valid <= 1'b1;
        out_sum   <= add_sum;
        out_cout  <= add_cout;
        out_id    <= grant_idx;
        out_tag   <= win_tag;
        rr_ptr    <= grant_idx + ID_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one `adder` instance (WIDTH-bit, ports a/b/sum/cout, carry-in tied 0) between NUM_REQ requesters, e.g. address-generation, branch-target and ALU issue ports of the OOO core.
- Round-robin arbiter accepts at most one operand pair per cycle through valid/ready handshakes.
- Returns the registered sum, carry-out, requester id and tag on a single output channel with backpressure.

Parameters:
- WIDTH, 32, operand/sum width passed to the adder.
- NUM_REQ, 4, number of requesters (≥2, power of two).
- TAG_W, 6, width of the opaque per-request tag (e.g. ROB index).
- ID_W, $clog2(NUM_REQ), width of the requester id.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero.
- req_a  in  NUM_REQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  packed operand B, same packing.
- req_tag  in  NUM_REQ*TAG_W  packed tags.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  a+b modulo 2^WIDTH.
- out_cout  out  1  carry-out of the addition.
- out_id  out  ID_W  index of the requester served.
- out_tag  out  TAG_W  tag of the served request.
- op_count  out  32  number of completed output handshakes, wraps at 2^32.

Behaviour:
- Reset, when rst=1 at a clock edge:
  - out_valid=0; out_sum, out_cout, out_id, out_tag and op_count = 0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 during the reset cycle.
- Output slot states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- can_accept = !out_valid | out_ready, combinational.
- Arbitration, combinational:
  - If can_accept, grant the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - req_ready = one-hot of the granted index; otherwise req_ready=0.
  - req_ready never depends on req_valid of the same requester beyond selection.
  - Requesters must hold valid/operands until ready (standard valid/ready).
- Accept, at a clock edge with a grant:
  - Operands of the winner are muxed into the adder.
  - out_sum/out_cout/out_tag/out_id load the adder result and winner data.
  - out_valid<=1; rr_ptr <= (winner+1) mod NUM_REQ.
- Latency and throughput:
  - Latency is exactly 1 cycle from accept to out_valid.
  - Throughput is 1 op/cycle while out_ready=1.
- Drain without accept (out_valid & out_ready, no req_valid): out_valid<=0; data outputs hold their last value.
- Stall (out_valid & !out_ready):
  - All outputs stable.
  - req_ready=0; rr_ptr unchanged.
- Simultaneous drain+accept: the new result replaces the old in the same edge, out_valid stays 1, and there is no bubble.
- op_count increments on every out_valid & out_ready edge and wraps 0xFFFFFFFF→0.
- Arithmetic:
  - Unsigned wraparound.
  - out_cout = bit WIDTH of the (WIDTH+1)-bit sum.
  - Example: 0xFFFFFFFF+0x00000001 → sum 0, cout 1.
- Fairness: a requester holding req_valid is accepted within NUM_REQ accepts after its first cycle of valid.
- rr_ptr only advances on accept; idle cycles leave it unchanged.
- Reset mid-operation: a pending result is discarded (out_valid→0 next cycle); the requester sees no ready and must re-issue after reset.
- X on req_a/req_b of non-granted or non-valid requesters must not propagate to outputs.

Test Plan:
1. Reset with req_valid=4'b1111 → req_ready=0, out_valid=0, op_count=0; first cycle after reset grants req 0 (req_ready=4'b0001).
2. All four valid with out_ready=1 held:
   - Grants 0,1,2,3,0 on consecutive cycles.
   - out_id sequence 0,1,2,3 one cycle later.
   - op_count reaches 4 after four output handshakes.
3. Req 2 alone with a=0xFFFFFFFF, b=0x00000001, tag=0x15 → next cycle out_valid=1, out_sum=0, out_cout=1, out_id=2, out_tag=0x15.
4. out_ready=0 for 5 cycles with result held:
   - Outputs stable, req_ready=0 throughout.
   - On out_ready=1, same-edge accept of the next request; out_valid stays 1.
5. 1000 random cycles (random valid, operands, tags, out_ready) → every result equals scoreboard (a+b)&mask with correct carry, tag and id, in issue order; no requester starved beyond 4 accepts.
6. Assert rst while out_valid=1 and req_valid=4'b0110:
   - Next cycle out_valid=0, rr_ptr=0.
   - After rst deasserts, req 1 is granted first.
